// File: rtl/openfire_boot_loader.sv
// Boot loader for the openFIRE data-memory port: streams an image into memory,
// reads it back, compares checksums, and releases the CPU reset only on a match.
module openfire_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 4096,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_data_out,
    input  logic [31:0] dmem_data_in,
    output logic        dmem_we,
    output logic        dmem_re,
    output logic [1:0]  dmem_input_sel,
    input  logic        dmem_done,
    output logic        cpu_reset,
    output logic        boot_done,
    output logic        boot_error,
    output logic [15:0] words_loaded
);

    localparam int IW = $clog2(MAX_WORDS + 1);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_WR_DATA, S_WR_REQ, S_WR_GAP,
        S_RD_REQ, S_RD_GAP, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t         state_reg;
    logic [IW-1:0]  index_reg;
    logic [IW-1:0]  len_reg;
    logic [31:0]    wsum_reg;
    logic [31:0]    rsum_reg;
    logic [TW-1:0]  tcnt_reg;

    logic           timed_state;
    logic           progress;
    logic [IW-1:0]  index_inc;

    function automatic logic [31:0] addr_of(input logic [IW-1:0] idx);
        return BASE_ADDR + (32'(idx) << 2);
    endfunction

    assign in_ready       = (state_reg == S_LEN) || (state_reg == S_WR_DATA);
    assign dmem_input_sel = 2'b00;
    assign index_inc      = index_reg + IW'(1);

    // Request states advance on done high, gap states on done low.
    always_comb begin
        timed_state = 1'b0;
        progress    = 1'b0;
        case (state_reg)
            S_WR_REQ, S_RD_REQ: begin timed_state = 1'b1; progress = dmem_done;  end
            S_WR_GAP, S_RD_GAP: begin timed_state = 1'b1; progress = !dmem_done; end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            index_reg     <= '0;
            len_reg       <= '0;
            wsum_reg      <= '0;
            rsum_reg      <= '0;
            tcnt_reg      <= '0;
            dmem_addr     <= '0;
            dmem_data_out <= '0;
            dmem_we       <= 1'b0;
            dmem_re       <= 1'b0;
            cpu_reset     <= 1'b1;
            boot_done     <= 1'b0;
            boot_error    <= 1'b0;
            words_loaded  <= '0;
        end else if (timed_state && !progress && tcnt_reg == TMAX) begin
            state_reg  <= S_ERROR;
            tcnt_reg   <= '0;
            dmem_we    <= 1'b0;
            dmem_re    <= 1'b0;
            boot_error <= 1'b1;
            cpu_reset  <= 1'b1;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        index_reg    <= '0;
                        wsum_reg     <= '0;
                        rsum_reg     <= '0;
                        words_loaded <= '0;
                        cpu_reset    <= 1'b1;
                        boot_done    <= 1'b0;
                        boot_error   <= 1'b0;
                        state_reg    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (in_valid) begin
                        if (in_data > 32'(MAX_WORDS)) begin
                            boot_error <= 1'b1;
                            state_reg  <= S_ERROR;
                        end else if (in_data == 32'd0) begin
                            boot_done <= 1'b1;
                            cpu_reset <= 1'b0;
                            state_reg <= S_DONE;
                        end else begin
                            len_reg   <= in_data[IW-1:0];
                            state_reg <= S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (in_valid) begin
                        dmem_data_out <= in_data;
                        wsum_reg      <= wsum_reg + in_data;
                        dmem_addr     <= addr_of(index_reg);
                        dmem_we       <= 1'b1;
                        tcnt_reg      <= '0;
                        state_reg     <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (progress) begin
                        dmem_we      <= 1'b0;
                        words_loaded <= words_loaded + 16'd1;
                        tcnt_reg     <= '0;
                        state_reg    <= S_WR_GAP;
                    end else begin
                        tcnt_reg <= tcnt_reg + TW'(1);
                    end
                end
                S_WR_GAP: begin
                    if (progress) begin
                        tcnt_reg <= '0;
                        if (index_inc == len_reg) begin
                            index_reg <= '0;
                            dmem_addr <= addr_of('0);
                            dmem_re   <= 1'b1;
                            state_reg <= S_RD_REQ;
                        end else begin
                            index_reg <= index_inc;
                            state_reg <= S_WR_DATA;
                        end
                    end else begin
                        tcnt_reg <= tcnt_reg + TW'(1);
                    end
                end
                S_RD_REQ: begin
                    if (progress) begin
                        rsum_reg  <= rsum_reg + dmem_data_in;
                        dmem_re   <= 1'b0;
                        tcnt_reg  <= '0;
                        state_reg <= S_RD_GAP;
                    end else begin
                        tcnt_reg <= tcnt_reg + TW'(1);
                    end
                end
                S_RD_GAP: begin
                    if (progress) begin
                        tcnt_reg  <= '0;
                        index_reg <= index_inc;
                        if (index_inc == len_reg) begin
                            state_reg <= S_CHECK;
                        end else begin
                            dmem_addr <= addr_of(index_inc);
                            dmem_re   <= 1'b1;
                            state_reg <= S_RD_REQ;
                        end
                    end else begin
                        tcnt_reg <= tcnt_reg + TW'(1);
                    end
                end
                S_CHECK: begin
                    if (rsum_reg == wsum_reg) begin
                        boot_done <= 1'b1;
                        cpu_reset <= 1'b0;
                        state_reg <= S_DONE;
                    end else begin
                        boot_error <= 1'b1;
                        state_reg  <= S_ERROR;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
